muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer for the multi-cycle MULT/MULTU/DIV/DIVU datapath and owner of the HI/LO registers.
//  Sits beside the EX-stage ALU and takes the decoded mult/div/mfhl/mthl one-hot controls plus rs/rt operands.
//  Drives the pipeline stall while a HI/LO consumer or a new mul/div waits on an in-flight op.
//  Returns HI or LO data for MFHI/MFLO.
// PARAMETERS
//  MUL_LAT   2   busy cycles for a multiply (1..4). Product is pipelined across MUL_LAT register stages.
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous reset, active-high
//  ex_valid    in   1   EX-stage instruction valid
//  flush       in   1   EX instruction cancelled (exception/eret); blocks its acceptance only
//  mult        in   2   [1]=MULTU [0]=MULT
//  div         in   2   [1]=DIVU  [0]=DIV
//  mfhl        in   2   [1]=MFHI  [0]=MFLO
//  mthl        in   2   [1]=MTHI  [0]=MTLO
//  src_a       in   32  rs operand (dividend / multiplicand / MTxx data)
//  src_b       in   32  rt operand (divisor / multiplier)
//  stall       out  1   hold IF/ID/EX this cycle
//  busy        out  1   mul or div in flight
//  hilo_rdata  out  32  HI if mfhl[1], LO if mfhl[0], else 0
// BEHAVIOUR
//  - Reset: state=IDLE, HI=LO=0, counter=0, busy=0, stall=0, hilo_rdata=0.
//  - States: IDLE, MUL, DIV, FIX.
//  - use = ex_valid & ~flush & |{mult,div,mfhl,mthl}.
//  - stall = use & busy (combinational). An op issued from IDLE does not stall itself.
//  - Accept in cycle T when use & state==IDLE. Priority when controls overlap: div > mult > mthl.
//    Within a pair, [1] (unsigned / HI) wins.
//  - MUL: busy during T+1..T+MUL_LAT. {HI,LO} = 64-bit product (signed for MULT), written at the edge
//    ending cycle T+MUL_LAT. Then IDLE.
//  - DIV: restoring divide on |operands|, 32 iterations, then FIX for sign correction; busy during T+1..T+33.
//    - Signed: quotient sign = a^b, remainder sign = a.
//    - Unsigned: no correction.
//    - LO=quotient, HI=remainder, written at the edge ending T+33.
//    - 0x80000000 / -1: LO=0x80000000, HI=0.
//  - Divide by zero: LO=32'hFFFFFFFF, HI=src_a (raw), both signed and unsigned.
//  - MTHI/MTLO: write HI/LO at the edge ending the accept cycle. No busy.
//  - MFHI/MFLO: hilo_rdata combinational from HI/LO, valid whenever ~stall. The first readable cycle
//    after a mul/div is the cycle busy falls.
//  - Operands are latched at accept; src_a/src_b may change afterwards.
//  - flush while busy: in-flight op completes normally.
//  - rst mid-op: abort, return to reset values next cycle.
//  - Counter 6-bit, cleared on accept and on reset; never wraps past 32.
// CONFIGURATION
//  - DIV_ZERO_FAST_EN defined: divisor==0 skips iteration. Busy only in T+1; HI/LO written at the edge
//    ending T+1.
//  - Undefined: divide by zero takes the full 33 busy cycles.
//  - Result values are identical either way.
// TESTING
//  1. MULT a=32'hFFFFFFFD, b=7, then MFLO next cycle -> stall 2 cycles (MUL_LAT=2);
//     LO=32'hFFFFFFEB, HI=32'hFFFFFFFF; hilo_rdata=32'hFFFFFFEB.
//  2. DIV a=-7, b=2, then MFHI -> stall exactly 33 cycles; LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
//  3. DIVU a=100, b=7 -> LO=14, HI=2. DIV a=32'h80000000, b=-1 -> LO=32'h80000000, HI=0.
//  4. DIVU a=5, b=0 -> LO=32'hFFFFFFFF, HI=5. Busy 33 cycles without DIV_ZERO_FAST_EN, 1 cycle with it.
//  5. rst asserted in busy cycle 10 of a DIV -> next cycle busy=0, stall=0, HI=LO=0; a following MTLO 9 writes LO=9.
//  6. MTHI 32'h1234 idle, MFHI next -> 32'h1234, no stall.
//     MULT issued with flush=1 -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer and HI/LO register owner.
// Multiply is pipelined over MUL_LAT stages. Divide is a 32-iteration restoring
// divide on operand magnitudes, followed by a sign-fix cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and
// finishes in one busy cycle.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        flush,
  input  logic [1:0]  mult,
  input  logic [1:0]  div,
  input  logic [1:0]  mfhl,
  input  logic [1:0]  mthl,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hilo_rdata
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, raw_a_q, raw_a_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [63:0] pipe_q [MUL_LAT];

  logic               op_use, accept, mul_signed, div_signed;
  logic signed [65:0] prod_full;
  logic [31:0]        a_abs, b_abs;
  logic [32:0]        shifted, diff;

  assign op_use = ex_valid & ~flush & (|{mult, div, mfhl, mthl});
  assign busy   = (state_q != IDLE);
  assign stall  = op_use & busy;
  assign accept = op_use & (state_q == IDLE);

  assign hilo_rdata = mfhl[1] ? hi_q : (mfhl[0] ? lo_q : '0);

  // MULTU wins over MULT, DIVU over DIV: [1] selects the unsigned form
  assign mul_signed = ~mult[1];
  assign div_signed = ~div[1];
  assign prod_full  = $signed({mul_signed & src_a[31], src_a}) *
                      $signed({mul_signed & src_b[31], src_b});
  assign a_abs = (div_signed & src_a[31]) ? -src_a : src_a;
  assign b_abs = (div_signed & src_b[31]) ? -src_b : src_b;

  // One restoring-divide iteration: shift in the next dividend bit, trial subtract
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};

  // Product pipeline: stage 0 captures at accept, later stages shift every cycle
  always_ff @(posedge clk) begin
    if (accept && (div == 2'b00) && (mult != 2'b00)) begin
      pipe_q[0] <= prod_full[63:0];
    end
    for (int unsigned i = 1; i < MUL_LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Next-state, HI/LO update and divider datapath
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    raw_a_d = raw_a_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (div != 2'b00) begin
            dvs_d   = b_abs;
            quo_d   = a_abs;
            rem_d   = '0;
            raw_a_d = src_a;
            qneg_d  = div_signed & (src_a[31] ^ src_b[31]);
            rneg_d  = div_signed & src_a[31];
            dz_d    = (src_b == '0);
            state_d = DIV;
`ifdef DIV_ZERO_FAST_EN
            if (src_b == '0) state_d = FIX;
`endif
          end else if (mult != 2'b00) begin
            state_d = MUL;
          end else if (mthl[1]) begin
            hi_d = src_a;
          end else if (mthl[0]) begin
            lo_d = src_a;
          end
        end
      end
      MUL: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MUL_LAT - 1)) begin
          {hi_d, lo_d} = pipe_q[MUL_LAT-1];
          state_d      = IDLE;
        end
      end
      DIV: begin
        cnt_d = cnt_q + 6'd1;
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        // Zero divisor overrides the iterated result so both timing modes agree
        if (dz_q) begin
          lo_d = '1;
          hi_d = raw_a_q;
        end else begin
          lo_d = qneg_q ? -quo_q : quo_q;
          hi_d = rneg_q ? -rem_q : rem_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control/data registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      raw_a_q <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      raw_a_q <= raw_a_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: expected HI/LO/latency are pushed at issue
// and popped when the following MFLO/MFHI is served.
module tb_muldiv_ctrl;

  localparam int unsigned LAT = 2;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, flush = 1'b0;
  logic [1:0]  mult = '0, div = '0, mfhl = '0, mthl = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        stall, busy;
  logic [31:0] hilo_rdata;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_hi = '0, m_lo = '0;

  muldiv_ctrl #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .flush(flush),
    .mult(mult), .div(div), .mfhl(mfhl), .mthl(mthl),
    .src_a(src_a), .src_b(src_b),
    .stall(stall), .busy(busy), .hilo_rdata(hilo_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one op for a single cycle from IDLE; model result pushed to scoreboard
  task automatic issue(input logic [1:0] mu, input logic [1:0] dv, input logic [1:0] mt,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb2;
    int     ia, ib;
    logic [63:0] p;
    e.lat = 0;
    if (dv != 2'b00) begin
      e.lat = (b == 32'd0) ? ZLAT : 33;
      if (b == 32'd0) begin
        m_lo = 32'hFFFFFFFF; m_hi = a;
      end else if (dv[1]) begin
        m_lo = a / b; m_hi = a % b;
      end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        m_lo = 32'h80000000; m_hi = 32'd0;
      end else begin
        ia = $signed(a); ib = $signed(b);
        m_lo = 32'(ia / ib); m_hi = 32'(ia % ib);
      end
    end else if (mu != 2'b00) begin
      e.lat = LAT;
      if (mu[1]) p = {32'd0, a} * {32'd0, b};
      else begin
        sa = longint'($signed(a)); sb2 = longint'($signed(b));
        p = 64'(sa * sb2);
      end
      {m_hi, m_lo} = p;
    end else if (mt[1]) m_hi = a;
    else if (mt[0]) m_lo = a;
    e.hi = m_hi; e.lo = m_lo;
    sb.push_back(e);
    ex_valid = 1'b1; flush = 1'b0;
    mult = mu; div = dv; mthl = mt; mfhl = '0;
    src_a = a; src_b = b;
    #1;
    chk("issue_no_self_stall", {31'd0, stall}, 32'd0);
    tick();
  endtask

  // Present MFLO, count stall cycles, then read LO and HI from the scoreboard entry
  task automatic readback(input string tag);
    exp_t e;
    int   n;
    e = sb.pop_front();
    mult = '0; div = '0; mthl = '0; mfhl = 2'b01; ex_valid = 1'b1;
    src_a = $urandom; src_b = $urandom;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(e.lat));
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({tag, "_lo"}, hilo_rdata, e.lo);
    mfhl = 2'b10;
    #1;
    chk({tag, "_hi"}, hilo_rdata, e.hi);
    ex_valid = 1'b0; mfhl = '0;
    tick();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick();
    mfhl = 2'b01; #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_lo", hilo_rdata, 32'd0);
    mfhl = 2'b10; #1;
    chk("rst_hi", hilo_rdata, 32'd0);
    mfhl = 2'b00;
    rst = 1'b0;
    tick();

    // 1: signed multiply, MFLO stalls MUL_LAT cycles
    issue(2'b01, 2'b00, 2'b00, 32'hFFFFFFFD, 32'd7);
    readback("mult_neg");
    chk("mult_neg_lo_const", m_lo, 32'hFFFFFFEB);
    issue(2'b10, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    readback("multu_max");

    // 2/3: signed and unsigned divides, overflow corner
    issue(2'b00, 2'b01, 2'b00, 32'hFFFFFFF9, 32'd2);
    readback("div_neg7_2");
    issue(2'b00, 2'b10, 2'b00, 32'd100, 32'd7);
    readback("divu_100_7");
    issue(2'b00, 2'b01, 2'b00, 32'h80000000, 32'hFFFFFFFF);
    readback("div_ovf");
    issue(2'b00, 2'b01, 2'b00, 32'd37, 32'hFFFFFFFB);
    readback("div_37_m5");

    // Overlapping controls: div beats mult
    issue(2'b01, 2'b10, 2'b01, 32'd1000, 32'd33);
    readback("prio_div");

    // 4: divide by zero, unsigned and signed
    issue(2'b00, 2'b10, 2'b00, 32'd5, 32'd0);
    readback("divu_zero");
    issue(2'b00, 2'b01, 2'b00, 32'hFFFFFFF0, 32'd0);
    readback("div_zero");

    // 5: reset in busy cycle 10 of a divide
    ex_valid = 1'b1; div = 2'b01; src_a = 32'd12345; src_b = 32'd11;
    tick();
    ex_valid = 1'b0; div = '0;
    for (int i = 1; i < 10; i++) tick();
    chk("mid_div_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex_valid = 1'b1; mfhl = 2'b01; #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_lo", hilo_rdata, 32'd0);
    mfhl = 2'b10; #1;
    chk("abort_hi", hilo_rdata, 32'd0);
    m_hi = '0; m_lo = '0;
    ex_valid = 1'b0; mfhl = '0;
    tick();
    issue(2'b00, 2'b00, 2'b01, 32'd9, 32'd0);
    readback("mtlo9");

    // 6: MTHI then MFHI without stall; flushed MULT has no effect
    issue(2'b00, 2'b00, 2'b10, 32'h1234, 32'd0);
    readback("mthi");
    ex_valid = 1'b1; flush = 1'b1; mult = 2'b01; src_a = 32'd5; src_b = 32'd6;
    #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0; mult = '0; ex_valid = 1'b0;
    #1;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("flush_busy_later", {31'd0, busy}, 32'd0);
    sb.push_back('{hi: m_hi, lo: m_lo, lat: 0});
    readback("flush_unchanged");

    // Flush asserted while a multiply is in flight does not cancel it
    issue(2'b01, 2'b00, 2'b00, 32'd300, 32'hFFFFFFFE);
    ex_valid = 1'b1; flush = 1'b1; mult = '0;
    #1;
    chk("flush_busy_inflight", {31'd0, busy}, 32'd1);
    flush = 1'b0; ex_valid = 1'b0;
    readback("mult_flush_inflight");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
